// File: rtl/rvfi_check_seq_pkg.sv
// Shared types and helpers for the formal check harness sequencer.
package rvfi_check_seq_pkg;

  typedef enum logic [1:0] {
    S_RST,
    S_RUN,
    S_DONE
  } seq_state_e;

  localparam int CNT_W_DEFAULT = 8;

  // Saturating add: result clamps at 2**w-1 instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int          w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/rvfi_popcount.sv
// Counts the asserted bits of rvfi_valid at CNT_W width (saturating).
module rvfi_popcount
  import rvfi_check_seq_pkg::*;
#(
  parameter int NRET  = 1,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic [NRET-1:0]  rvfi_valid,
  output logic [CNT_W-1:0] count
);

  // Sum one bit per retire channel.
  always_comb begin
    count = '0;
    for (int i = 0; i < NRET; i++) begin
      count = CNT_W'(sat_add(32'(count), 32'(rvfi_valid[i]), CNT_W));
    end
  end

endmodule

// File: rtl/rvfi_check_sequencer.sv
// Formal check harness sequencer: DUT reset pulse, cycle/retire counters and
// a one-shot check strobe gated on a minimum retirement count.
// Optional macro RISCV_FORMAL_CHECK_WINDOW_EN widens the check slot to
// CHECK_CYCLE..CHECK_CYCLE+WINDOW and lets check_req pick the cycle.
// Because check is registered, the decision for slot cycle c is taken in the
// cycle before it; rvfi_valid and check_req of that cycle are included.
module rvfi_check_sequencer
  import rvfi_check_seq_pkg::*;
#(
  parameter int NRET         = 1,
  parameter int RESET_CYCLES = 1,
  parameter int CHECK_CYCLE  = 20,
  parameter int MIN_RETIRE   = 1,
  parameter int WINDOW       = 4,
  parameter int CNT_W        = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NRET-1:0]  rvfi_valid,
  input  logic             check_req,
  output logic             dut_reset,
  output logic             check,
  output logic             done,
  output logic             starved,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
`ifdef RISCV_FORMAL_CHECK_WINDOW_EN
  localparam int LAST_SLOT = CHECK_CYCLE + WINDOW;
`else
  localparam int LAST_SLOT = CHECK_CYCLE;
`endif

  seq_state_e       state_q, state_nx;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_nx;
  logic [CNT_W-1:0] pop, pop_g, cycle_nx, retire_nx;
  logic             check_nx, done_nx, starved_nx, gate_nx, slot_nx, req_ok;

  rvfi_popcount #(.NRET(NRET), .CNT_W(CNT_W)) u_popcount (
    .rvfi_valid (rvfi_valid),
    .count      (pop)
  );

`ifdef RISCV_FORMAL_CHECK_WINDOW_EN
  // Fire on the first requested cycle of the window, or force on the last.
  always_comb begin
    slot_nx = (cycle_nx >= CNT_W'(CHECK_CYCLE)) && (cycle_nx <= CNT_W'(LAST_SLOT));
    req_ok  = check_req || (cycle_nx == CNT_W'(LAST_SLOT));
  end
`else
  logic unused_cfg;
  assign unused_cfg = check_req ^ (WINDOW == 0);

  // Single-cycle slot; check_req has no effect.
  always_comb begin
    slot_nx = (cycle_nx == CNT_W'(CHECK_CYCLE));
    req_ok  = 1'b1;
  end
`endif

  // Next-state, counter and strobe decode.
  always_comb begin
    state_nx   = state_q;
    rst_cnt_nx = rst_cnt_q;
    done_nx    = done;
    starved_nx = starved;
    pop_g      = dut_reset ? '0 : pop;
    cycle_nx   = CNT_W'(sat_add(32'(cycle_cnt), 32'd1, CNT_W));
    retire_nx  = CNT_W'(sat_add(32'(retire_cnt), 32'(pop_g), CNT_W));
    unique case (state_q)
      S_RST: begin
        cycle_nx   = '0;
        retire_nx  = '0;
        rst_cnt_nx = rst_cnt_q + RW'(1);
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) state_nx = S_RUN;
      end
      S_RUN: begin
        // Slot is over once check has been shown or the last slot cycle passes.
        if (check || (cycle_cnt == CNT_W'(LAST_SLOT))) begin
          state_nx   = S_DONE;
          done_nx    = 1'b1;
          starved_nx = !check;
        end
      end
      default: ;
    endcase
    gate_nx  = (MIN_RETIRE == 0) || (32'(retire_nx) >= 32'(MIN_RETIRE));
    check_nx = (state_nx == S_RUN) && slot_nx && gate_nx && req_ok;
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_RST;
      rst_cnt_q  <= '0;
      dut_reset  <= 1'b1;
      check      <= 1'b0;
      done       <= 1'b0;
      starved    <= 1'b0;
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      state_q    <= state_nx;
      rst_cnt_q  <= rst_cnt_nx;
      dut_reset  <= (state_nx == S_RST);
      check      <= check_nx;
      done       <= done_nx;
      starved    <= starved_nx;
      cycle_cnt  <= cycle_nx;
      retire_cnt <= retire_nx;
    end
  end

endmodule
